// File: rtl/hex_pkg.sv
//------------------------------------------------------------------------------
// hex_pkg : shared types, constants and active-low 7-segment decode table
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hex_pkg;

    localparam int HEX_DIGITS = 8;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t       SEG_OFF = 7'h7F;
    localparam logic [7:0] SEL_OFF = 8'hFF;

    // Active-low segments, bit0 = a ... bit6 = g
    function automatic seg_t seg_decode(input nibble_t n);
        seg_t s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_seg_decoder.sv
//------------------------------------------------------------------------------
// hex_seg_decoder : combinational nibble to active-low segment decoder
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_seg_decoder
    import hex_pkg::*;
(
    input  nibble_t i_nibble,
    output seg_t    o_seg
);

    assign o_seg = seg_decode(i_nibble);

endmodule

`default_nettype wire

// File: rtl/hex_scan_driver.sv
//------------------------------------------------------------------------------
// hex_scan_driver : 8-digit time-multiplexed 7-segment scanner, registered
// outputs. Optional inter-slot blanking with macro HEX_SCAN_BLANK_EN.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_scan_driver
    import hex_pkg::*;
#(
    parameter int DIV_CYCLES   = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  nibble_t    hex0_i,
    input  nibble_t    hex1_i,
    input  nibble_t    hex2_i,
    input  nibble_t    hex3_i,
    input  nibble_t    hex4_i,
    input  nibble_t    hex5_i,
    input  nibble_t    hex6_i,
    input  nibble_t    hex7_i,
    input  logic [7:0] bitmask_i,
    output seg_t       hex_led_o,
    output logic [7:0] hex_sel_o,
    output logic       frame_o
);

    localparam int                 c_CNT_W   = $clog2(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DIV_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK   = c_CNT_W'(BLANK_CYCLES);
`ifdef HEX_SCAN_BLANK_EN
    localparam bit                 c_BLANK_EN = 1'b1;
`else
    localparam bit                 c_BLANK_EN = 1'b0;
`endif

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic               r_wrapped;   // suppresses frame_o on the first pass after reset

    nibble_t w_digits [HEX_DIGITS];
    nibble_t w_nibble;
    seg_t    w_seg;
    logic    w_blank;
    logic    w_lit;

    assign w_digits[0] = hex0_i;
    assign w_digits[1] = hex1_i;
    assign w_digits[2] = hex2_i;
    assign w_digits[3] = hex3_i;
    assign w_digits[4] = hex4_i;
    assign w_digits[5] = hex5_i;
    assign w_digits[6] = hex6_i;
    assign w_digits[7] = hex7_i;

    assign w_nibble = w_digits[r_idx];
    assign w_blank  = c_BLANK_EN && (r_cnt < c_BLANK);
    assign w_lit    = bitmask_i[r_idx] && !w_blank;

    hex_seg_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wrapped <= 1'b0;
            hex_sel_o <= SEL_OFF;
            hex_led_o <= SEG_OFF;
            frame_o   <= 1'b0;
        end else begin
            if (r_cnt == c_CNT_MAX) begin
                r_cnt <= '0;
                r_idx <= r_idx + 3'd1;
                if (r_idx == 3'd7) begin
                    r_wrapped <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            // Single shifted-zero anode per cycle: no overlap across idx changes
            hex_sel_o <= w_lit ? ~(8'h01 << r_idx) : SEL_OFF;
            hex_led_o <= w_lit ? w_seg : SEG_OFF;
            frame_o   <= r_wrapped && (r_idx == 3'd0) && (r_cnt == '0);
        end
    end

endmodule

`default_nettype wire

// File: doc/hex_scan_driver.md
# hex_scan_driver

Time-multiplexed scanner for the 8-digit seven-segment display, sitting directly downstream of the hex system-bus controller. Takes the eight 4-bit digit values and the digit-enable bitmask held by the controller, cycles through the digits at a programmable slot rate, decodes each nibble to segments, and drives the board's active-low anode and segment lines. Outputs are fully registered, glitch-free, and can optionally be blanked between slots to suppress ghosting.

## Interface
- DIV_CYCLES, 100000: clock cycles per digit slot, legal range ≥ 2. The default gives 1 ms slots and a 125 Hz frame at 100 MHz.
- BLANK_CYCLES, 1000: blanked cycles at the start of each slot. Must be < DIV_CYCLES. Used only with HEX_SCAN_BLANK_EN.
- clk_i  input  1  system clock
- rst_i  input  1  reset; one clock; reset is synchronous and active-low
- hex0_i … hex7_i  input  4 each  digit values; hex0_i is the rightmost digit
- bitmask_i  input  8  per-digit enable; bit n enables digit n
- hex_led_o  output  7  segments, active-low, bit0=a … bit6=g
- hex_sel_o  output  8  anodes, active-low, bit n = digit n
- frame_o  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0

## Operation
- Prescaler `cnt` counts 0 … DIV_CYCLES-1.
  - When cnt == DIV_CYCLES-1: cnt←0 and digit index `idx`←idx+1 (3-bit, 7 wraps to 0).
- Output computation, registered every cycle from the current idx, cnt and inputs:
  - Digit enabled (bitmask_i[idx]=1): hex_sel_o = ~(8'b1<<idx), hex_led_o = decode(hex{idx}_i).
  - Digit disabled: hex_sel_o = 8'hFF, hex_led_o = 7'h7F. The slot time is still consumed, so brightness is independent of the mask.
- Decode table, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- frame_o is registered and asserted for one cycle, coincident with the first cycle in which the outputs reflect idx=0 after a 7→0 wrap.
- Inputs are not latched per slot. A change to the selected digit's value or enable bit mid-slot appears on the outputs on the next edge.
- Reset (rst_i=0 at a rising edge), including mid-slot:
  - cnt=0, idx=0, hex_sel_o=8'hFF, hex_led_o=7'h7F, frame_o=0.
  - The scan restarts at digit 0 with a full slot.

## Timing
- Latency is one clock from (idx, cnt, inputs) to the outputs.
- After reset release, the first edge drives digit 0. Without the macro, digit 0 is shown for DIV_CYCLES cycles, then digit 1, and so on.
- Frame period is exactly 8·DIV_CYCLES cycles. frame_o has the same period; no pulse occurs on the first pass after reset.
- At most one anode is low in any cycle. Anodes never overlap, even on the cycle of an idx change.

## Configuration
- HEX_SCAN_BLANK_EN
  - Defined: while cnt < BLANK_CYCLES, hex_sel_o=8'hFF and hex_led_o=7'h7F regardless of the mask. Each digit is lit for DIV_CYCLES-BLANK_CYCLES cycles per slot.
  - Undefined: no blanking. BLANK_CYCLES is ignored and the digit is lit for the whole slot.
- Slot and frame periods are identical in both builds.

## Structure
- Package hex_pkg holds:
  - HEX_DIGITS=8, the seg_t (logic [6:0]) and nibble_t (logic [3:0]) typedefs.
  - SEG_OFF=7'h7F and SEL_OFF=8'hFF.
  - The decode table as a function seg_decode(nibble_t).
- One sub-module: hex_seg_decoder, a combinational 4→7 wrapper around seg_decode, instantiated once on the muxed nibble.
- Prescaler, index counter, digit mux and output registers live in hex_scan_driver.

## Test plan
All scenarios use DIV_CYCLES=4 and BLANK_CYCLES=1.
- Reset held 3 cycles mid-slot at idx=5 → hex_sel_o=FF, hex_led_o=7F, frame_o=0. First post-reset edge shows digit 0.
- hex0..7 = 0…7, bitmask=FF, no macro → hex_sel_o steps FE, FD, FB … 7F, 4 cycles each. hex_led_o steps 40, 79, 24, 30, 19, 12, 02, 78. frame_o pulses every 32 cycles.
- bitmask=0x05, hex0=A, hex2=F → digit 0 shows sel FE / led 08, digit 2 shows FB / 0E. The other six slots show FF/7F, and each slot still lasts 4 cycles.
- HEX_SCAN_BLANK_EN defined, bitmask=FF, all digits 8 → every slot is 1 cycle FF/7F, then 3 cycles of the digit's anode with led=00. Never more than one anode low.
- Mid-slot change of hex3 from 1 to 9 while idx=3 → hex_led_o changes 79→10 on the next edge, with no change to hex_sel_o.
- Input sweep of all 16 nibble values on hex0 → hex_led_o matches the decode table exactly.
